morra_driver: RTL and testbench

Player-side front end for the MorraCinese game FSMD. Accepts one game configuration and a stream of moves from two independent player sources over valid/ready handshakes. Pairs the moves and issues each pair to the game for exactly one cycle, then reads back the round (`manche`) and game (`partita`) result. Sits between the player inputs and the `primo`/`secondo`/`inizia` ports of the game block, driving them the way the game's bench does, but cycle-accurately and under handshake control.

---
 rtl/morra_driver_if.sv | 23 ++
 rtl/morra_driver.sv | 150 +++++++++++++++
 tb/tb_morra_driver.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/morra_driver_if.sv
// Handshake bundle between the player/config sources and morra_driver.
// The driver uses the slave modport; the player side uses master.
interface morra_driver_if;
    logic       cfg_valid;
    logic [3:0] cfg_max;
    logic       cfg_ready;
    logic       p1_valid;
    logic [1:0] p1_move;
    logic       p1_ready;
    logic       p2_valid;
    logic [1:0] p2_move;
    logic       p2_ready;

    modport master (
        output cfg_valid, cfg_max, p1_valid, p1_move, p2_valid, p2_move,
        input  cfg_ready, p1_ready, p2_ready
    );

    modport slave (
        input  cfg_valid, cfg_max, p1_valid, p1_move, p2_valid, p2_move,
        output cfg_ready, p1_ready, p2_ready
    );
endinterface

// File: rtl/morra_driver.sv
// Player-side front end for the MorraCinese game: pairs two handshaked move
// streams into one-cycle rounds. Define MORRA_DRV_STATS_EN for round counters.
module morra_driver (
    input  logic          clk,
    input  logic          reset,
    morra_driver_if.slave bus,
    output logic [1:0]    primo,
    output logic [1:0]    secondo,
    output logic          inizia,
    input  logic [1:0]    manche,
    input  logic [1:0]    partita,
    output logic          round_done,
    output logic [1:0]    last_manche,
    output logic          game_over,
    output logic [1:0]    winner
`ifdef MORRA_DRV_STATS_EN
    ,
    output logic [4:0]    wins1,
    output logic [4:0]    wins2,
    output logic [4:0]    ties,
    output logic [4:0]    invalid
`endif
);

    typedef enum logic [2:0] {
        st_idle, st_start, st_collect, st_issue, st_result, st_done
    } state_t;

    state_t     state, state_n;
    logic       have1, have2, have1_n, have2_n;
    logic [1:0] buf1, buf2, buf1_n, buf2_n;
    logic [3:0] max_q, max_n;

`ifdef MORRA_DRV_STATS_EN
    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_n = state;
        have1_n = have1;
        have2_n = have2;
        buf1_n  = buf1;
        buf2_n  = buf2;
        max_n   = max_q;
        case (state)
            st_idle, st_done: begin
                if (bus.cfg_valid && bus.cfg_ready) begin
                    max_n   = bus.cfg_max;
                    state_n = st_start;
                end
            end
            st_start: state_n = st_collect;
            st_collect: begin
                // The players are independent: either, both or neither may land this cycle.
                if (bus.p1_valid && bus.p1_ready) begin
                    buf1_n  = bus.p1_move;
                    have1_n = 1'b1;
                end
                if (bus.p2_valid && bus.p2_ready) begin
                    buf2_n  = bus.p2_move;
                    have2_n = 1'b1;
                end
                if (have1_n && have2_n) state_n = st_issue;
            end
            st_issue: begin
                have1_n = 1'b0;
                have2_n = 1'b0;
                state_n = st_result;
            end
            st_result: state_n = (partita != 2'b00) ? st_done : st_collect;
            default:   state_n = st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the move buffers are reset along with their valid flags so a reset game never replays stale moves.
            state         <= st_idle;
            have1         <= 1'b0;
            have2         <= 1'b0;
            buf1          <= 2'b00;
            buf2          <= 2'b00;
            max_q         <= 4'd0;
            bus.cfg_ready <= 1'b1;
            bus.p1_ready  <= 1'b0;
            bus.p2_ready  <= 1'b0;
            primo         <= 2'b00;
            secondo       <= 2'b00;
            inizia        <= 1'b0;
            round_done    <= 1'b0;
            last_manche   <= 2'b00;
            game_over     <= 1'b0;
            winner        <= 2'b00;
`ifdef MORRA_DRV_STATS_EN
            wins1         <= 5'd0;
            wins2         <= 5'd0;
            ties          <= 5'd0;
            invalid       <= 5'd0;
`endif
        end else begin
            // NOTE: non-blocking throughout, so every register samples pre-edge values.
            state <= state_n;
            have1 <= have1_n;
            have2 <= have2_n;
            buf1  <= buf1_n;
            buf2  <= buf2_n;
            max_q <= max_n;

            // Outputs are decoded from the next state so they are registers aligned with it.
            bus.cfg_ready <= (state_n == st_idle) || (state_n == st_done);
            bus.p1_ready  <= (state_n == st_collect) && !have1_n;
            bus.p2_ready  <= (state_n == st_collect) && !have2_n;
            inizia        <= (state_n == st_start);
            round_done    <= (state_n == st_result);
            game_over     <= (state_n == st_done);
            primo   <= (state_n == st_start) ? max_n[3:2] :
                       (state_n == st_issue) ? buf1_n     : 2'b00;
            secondo <= (state_n == st_start) ? max_n[1:0] :
                       (state_n == st_issue) ? buf2_n     : 2'b00;

            if (state_n == st_start) begin
                last_manche <= 2'b00;
                winner      <= 2'b00;
            end else if (state == st_result) begin
                last_manche <= manche;
                if (partita != 2'b00) winner <= partita;
            end

`ifdef MORRA_DRV_STATS_EN
            if (state_n == st_start) begin
                wins1   <= 5'd0;
                wins2   <= 5'd0;
                ties    <= 5'd0;
                invalid <= 5'd0;
            end else if (state == st_result) begin
                case (manche)
                    2'b01:   wins1   <= sat_inc(wins1);
                    2'b10:   wins2   <= sat_inc(wins2);
                    2'b11:   ties    <= sat_inc(ties);
                    default: invalid <= sat_inc(invalid);
                endcase
            end
`endif
        end
    end

endmodule

// File: tb/tb_morra_driver.sv
// Bench for morra_driver: directed game tables plus randomized games scored
// against a round-level model of the MorraCinese rules.
module tb_morra_driver;
    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] primo, secondo, last_manche, winner;
    logic       inizia, round_done, game_over;
    logic [1:0] manche  = 2'b00;
    logic [1:0] partita = 2'b00;
`ifdef MORRA_DRV_STATS_EN
    logic [4:0] wins1, wins2, ties, invalid;
`endif
    int n_cmp  = 0;
    int n_fail = 0;

    morra_driver_if bus ();

    morra_driver dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .primo      (primo),
        .secondo    (secondo),
        .inizia     (inizia),
        .manche     (manche),
        .partita    (partita),
        .round_done (round_done),
        .last_manche(last_manche),
        .game_over  (game_over),
        .winner     (winner)
`ifdef MORRA_DRV_STATS_EN
        ,
        .wins1      (wins1),
        .wins2      (wins2),
        .ties       (ties),
        .invalid    (invalid)
`endif
    );

    always #5 clk = ~clk;

    // Game rules: 00 or a repeat of the previous winner's move voids the round;
    // a lead of 3 ends the game early, otherwise it ends after lim valid rounds.
    typedef struct {
        int         w1, w2, n, lim;
        logic [1:0] lw, lm, m, res;
    } game_t;

    function automatic logic [1:0] judge(input logic [1:0] a, b, lw, lm);
        if (a == 2'b00 || b == 2'b00) return 2'b00;
        if ((lw == 2'b01 && a == lm) || (lw == 2'b10 && b == lm)) return 2'b00;
        if (a == b) return 2'b11;
        if ((a == 2'b01 && b == 2'b11) || (a == 2'b10 && b == 2'b01) ||
            (a == 2'b11 && b == 2'b10)) return 2'b01;
        return 2'b10;
    endfunction

    function automatic game_t new_game(input int lim);
        game_t g;
        g.w1 = 0; g.w2 = 0; g.n = 0; g.lim = lim;
        g.lw = 2'b00; g.lm = 2'b00; g.m = 2'b00; g.res = 2'b00;
        return g;
    endfunction

    function automatic game_t play(input game_t g, input logic [1:0] a, b);
        game_t q;
        q   = g;
        q.m = judge(a, b, g.lw, g.lm);
        if (q.m != 2'b00) begin
            q.n++;
            if (q.m == 2'b01) begin q.w1++; q.lw = 2'b01; q.lm = a; end
            else if (q.m == 2'b10) begin q.w2++; q.lw = 2'b10; q.lm = b; end
            else q.lw = 2'b11;
            if (q.w1 - q.w2 >= 3) q.res = 2'b01;
            else if (q.w2 - q.w1 >= 3) q.res = 2'b10;
            else if (q.n >= q.lim) q.res = (q.w1 > q.w2) ? 2'b01 : (q.w2 > q.w1) ? 2'b10 : 2'b11;
        end
        return q;
    endfunction

    // Registered game block, answering the driver as the real game would.
    game_t gm = new_game(4);
    always @(posedge clk) begin
        if (inizia) begin
            gm = new_game(int'({primo, secondo}) + 4);
            manche  <= 2'b00;
            partita <= 2'b00;
        end else if (gm.res == 2'b00) begin
            gm = play(gm, primo, secondo);
            manche  <= gm.m;
            partita <= gm.res;
        end else begin
            manche <= 2'b00;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(input logic [3:0] m);
        bus.cfg_valid = 1'b1;
        bus.cfg_max   = m;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    // Both players offer in the same cycle; ends at t+3.
    task automatic play_round(input logic [1:0] a, b, exp, input logic last);
        bus.p1_valid = 1'b1; bus.p1_move = a;
        bus.p2_valid = 1'b1; bus.p2_move = b;
        tick();
        bus.p1_valid = 1'b0; bus.p2_valid = 1'b0;
        check("issue_primo", primo, a);
        check("issue_secondo", secondo, b);
        check("issue_inizia", inizia, 0);
        tick();
        check("round_done", round_done, 1);
        tick();
        check("last_manche", last_manche, exp);
        check("round_done_pulse", round_done, 0);
        check("game_over", game_over, last);
        check("p1_ready_again", bus.p1_ready, !last);
    endtask

    typedef struct { logic [1:0] m1, m2, exp; } round_vec_t;
    round_vec_t rv[9];

    game_t      sb;
    int         s_cnt[4];

    initial begin
        // Rounds 2..7 of the draw game, then the three rounds of the early-win game.
        rv[0] = '{2'b11, 2'b10, 2'b00};
        rv[1] = '{2'b01, 2'b11, 2'b01};
        rv[2] = '{2'b11, 2'b11, 2'b11};
        rv[3] = '{2'b11, 2'b10, 2'b01};
        rv[4] = '{2'b01, 2'b10, 2'b10};
        rv[5] = '{2'b11, 2'b11, 2'b11};
        rv[6] = '{2'b01, 2'b11, 2'b01};
        rv[7] = '{2'b10, 2'b01, 2'b01};
        rv[8] = '{2'b11, 2'b10, 2'b01};

        bus.cfg_valid = 1'b0; bus.cfg_max = 4'd0;
        bus.p1_valid = 1'b0; bus.p1_move = 2'b00;
        bus.p2_valid = 1'b0; bus.p2_move = 2'b00;

        tick(); tick();
        check("rst_cfg_ready", bus.cfg_ready, 1);
        check("rst_p1_ready", bus.p1_ready, 0);
        check("rst_inizia", inizia, 0);
        check("rst_primo", primo, 0);
        check("rst_game_over", game_over, 0);
        check("rst_winner", winner, 0);
        reset = 1'b0;

        // Configuration with cfg_max=0010.
        start_game(4'b0010);
        check("cfg_inizia", inizia, 1);
        check("cfg_primo", primo, 2'b00);
        check("cfg_secondo", secondo, 2'b10);
        check("cfg_ready_low", bus.cfg_ready, 0);
        tick();
        check("cfg_inizia_one_cycle", inizia, 0);
        check("cfg_secondo_idle", secondo, 0);
        check("cfg_p1_ready", bus.p1_ready, 1);
        check("cfg_p2_ready", bus.p2_ready, 1);

        // Skewed handshake, also round 1 of the draw game; a new-game request
        // held during play must be ignored.
        bus.p1_valid = 1'b1; bus.p1_move = 2'b01;
        tick();
        bus.p1_valid = 1'b0;
        bus.cfg_valid = 1'b1; bus.cfg_max = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            check("skew_p1_ready_low", bus.p1_ready, 0);
            check("skew_p2_ready_high", bus.p2_ready, 1);
            check("skew_cfg_ignored", inizia, 0);
            check("skew_cfg_ready_low", bus.cfg_ready, 0);
            if (i < 3) tick();
        end
        bus.p2_valid = 1'b1; bus.p2_move = 2'b10;
        tick();
        bus.p2_valid = 1'b0; bus.cfg_valid = 1'b0;
        check("skew_issue_primo", primo, 2'b01);
        check("skew_issue_secondo", secondo, 2'b10);
        check("skew_issue_no_done", round_done, 0);
        tick();
        check("skew_round_done", round_done, 1);
        tick();
        check("skew_last_manche", last_manche, 2'b10);
        check("skew_p1_ready_back", bus.p1_ready, 1);

        for (int i = 0; i < 6; i++) play_round(rv[i].m1, rv[i].m2, rv[i].exp, i == 5);
        check("draw_winner", winner, 2'b11);
        check("draw_cfg_ready", bus.cfg_ready, 1);
`ifdef MORRA_DRV_STATS_EN
        check("draw_wins1", wins1, 2);
        check("draw_wins2", wins2, 2);
        check("draw_ties", ties, 2);
        check("draw_invalid", invalid, 1);
`endif

        // Restart from DONE, then an early P1 win.
        start_game(4'b1111);
        check("restart_inizia", inizia, 1);
        check("restart_winner", winner, 0);
        check("restart_last_manche", last_manche, 0);
        check("restart_game_over", game_over, 0);
        check("restart_primo", primo, 2'b11);
`ifdef MORRA_DRV_STATS_EN
        check("restart_stats", {wins1, wins2, ties, invalid}, 0);
`endif
        tick();
        for (int i = 6; i < 9; i++) play_round(rv[i].m1, rv[i].m2, rv[i].exp, i == 8);
        check("early_winner", winner, 2'b01);
        bus.p1_valid = 1'b1; bus.p1_move = 2'b01;
        bus.p2_valid = 1'b1; bus.p2_move = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("done_p1_ignored", bus.p1_ready, 0);
            check("done_no_round", round_done, 0);
            check("done_primo_idle", primo, 0);
            check("done_held", game_over, 1);
        end
        bus.p1_valid = 1'b0; bus.p2_valid = 1'b0;

        // Reset in COLLECT with buffer 1 full.
        start_game(4'b0000);
        tick();
        bus.p1_valid = 1'b1; bus.p1_move = 2'b11;
        tick();
        bus.p1_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_cfg_ready", bus.cfg_ready, 1);
        check("midrst_p1_ready", bus.p1_ready, 0);
        check("midrst_p2_ready", bus.p2_ready, 0);
        check("midrst_outs", {primo, secondo, inizia, round_done, game_over}, 0);
        check("midrst_results", {last_manche, winner}, 0);
        start_game(4'b0000);
        tick();
        bus.p2_valid = 1'b1; bus.p2_move = 2'b01;
        tick();
        bus.p2_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("midrst_buf1_empty", bus.p1_ready, 1);
            check("midrst_no_round", round_done, 0);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Randomized games scored at round level.
        for (int g = 0; g < 4; g++) begin
            logic [3:0] cm;
            logic [1:0] q1[$];
            logic [1:0] q2[$];
            logic [1:0] prev_p, prev_s, exp_m, e1, e2;
            bit         pend, over;
            cm = 4'($urandom_range(0, 15));
            q1.delete(); q2.delete();
            sb = new_game(int'(cm) + 4);
            for (int k = 0; k < 4; k++) s_cnt[k] = 0;
            pend = 0; over = 0; prev_p = 2'b00; prev_s = 2'b00; exp_m = 2'b00;
            start_game(cm);
            tick();
            for (int c = 0; c < 3000 && !over; c++) begin
                bus.p1_valid = ($urandom_range(0, 2) != 0);
                bus.p1_move  = 2'($urandom_range(0, 3));
                bus.p2_valid = ($urandom_range(0, 2) != 0);
                bus.p2_move  = 2'($urandom_range(0, 3));
                if (bus.p1_valid && bus.p1_ready) q1.push_back(bus.p1_move);
                if (bus.p2_valid && bus.p2_ready) q2.push_back(bus.p2_move);
                tick();
                if (pend) begin
                    pend = 0;
                    check("rnd_last_manche", last_manche, exp_m);
                    check("rnd_game_over", game_over, sb.res != 2'b00);
                    if (sb.res != 2'b00) begin
                        over = 1;
                        check("rnd_winner", winner, sb.res);
`ifdef MORRA_DRV_STATS_EN
                        check("rnd_wins1", wins1, (s_cnt[1] > 31) ? 31 : s_cnt[1]);
                        check("rnd_wins2", wins2, (s_cnt[2] > 31) ? 31 : s_cnt[2]);
                        check("rnd_ties", ties, (s_cnt[3] > 31) ? 31 : s_cnt[3]);
                        check("rnd_invalid", invalid, (s_cnt[0] > 31) ? 31 : s_cnt[0]);
`endif
                    end
                end
                if (round_done) begin
                    check("rnd_moves_pending", (q1.size() != 0) && (q2.size() != 0), 1);
                    if (q1.size() != 0 && q2.size() != 0) begin
                        e1 = q1.pop_front();
                        e2 = q2.pop_front();
                        check("rnd_issue_pair", {prev_p, prev_s}, {e1, e2});
                        sb = play(sb, e1, e2);
                        s_cnt[sb.m]++;
                        exp_m = sb.m;
                        pend  = 1;
                    end
                end
                prev_p = primo;
                prev_s = secondo;
            end
            bus.p1_valid = 1'b0;
            bus.p2_valid = 1'b0;
            check("rnd_game_finished", over, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
